// File: rtl/video_timing_pkg.sv
// Shared raster timing types, preset modes and
// the config validity check for the timing generator.
package video_timing_pkg;

  localparam int TW = 12;

  typedef struct packed {
    logic [TW-1:0] h_act;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] v_act;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_720P = '{
    h_act: TW'(1280), h_fp: TW'(110),
    h_sync: TW'(40), h_bp: TW'(220),
    v_act: TW'(720), v_fp: TW'(5),
    v_sync: TW'(5), v_bp: TW'(20)
  };

  localparam timing_t TIMING_1080P = '{
    h_act: TW'(1920), h_fp: TW'(88),
    h_sync: TW'(44), h_bp: TW'(148),
    v_act: TW'(1080), v_fp: TW'(4),
    v_sync: TW'(5), v_bp: TW'(36)
  };

  // Largest legal line or frame total
  localparam logic [TW+1:0] MAX_TOT =
    {2'b01, {TW{1'b0}}};

  function automatic logic [TW+1:0] h_total(
    input timing_t t
  );
    return {2'b00, t.h_act} + {2'b00, t.h_fp}
         + {2'b00, t.h_sync} + {2'b00, t.h_bp};
  endfunction

  function automatic logic [TW+1:0] v_total(
    input timing_t t
  );
    return {2'b00, t.v_act} + {2'b00, t.v_fp}
         + {2'b00, t.v_sync} + {2'b00, t.v_bp};
  endfunction

  function automatic logic timing_valid(
    input timing_t t
  );
    return (t.h_act != '0) && (t.h_sync != '0)
        && (t.v_act != '0) && (t.v_sync != '0)
        && (h_total(t) <= MAX_TOT)
        && (v_total(t) <= MAX_TOT);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator with
// a one-entry shadow that is applied on frame wrap.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int W         = TW,
  parameter int DEF_H_ACT = 1280,
  parameter int DEF_H_FP  = 110,
  parameter int DEF_H_SYNC = 40,
  parameter int DEF_H_BP  = 220,
  parameter int DEF_V_ACT = 720,
  parameter int DEF_V_FP  = 5,
  parameter int DEF_V_SYNC = 5,
  parameter int DEF_V_BP  = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pix_en,
  input  logic [W-1:0] cfg_h_act,
  input  logic [W-1:0] cfg_h_fp,
  input  logic [W-1:0] cfg_h_sync,
  input  logic [W-1:0] cfg_h_bp,
  input  logic [W-1:0] cfg_v_act,
  input  logic [W-1:0] cfg_v_fp,
  input  logic [W-1:0] cfg_v_sync,
  input  logic [W-1:0] cfg_v_bp,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] h_count,
  output logic [W-1:0] v_count,
  output logic         de,
  output logic         hsync,
  output logic         vsync,
  output logic         line_start,
  output logic         frame_start
);

  localparam timing_t DEF_T = '{
    h_act: TW'(DEF_H_ACT), h_fp: TW'(DEF_H_FP),
    h_sync: TW'(DEF_H_SYNC), h_bp: TW'(DEF_H_BP),
    v_act: TW'(DEF_V_ACT), v_fp: TW'(DEF_V_FP),
    v_sync: TW'(DEF_V_SYNC), v_bp: TW'(DEF_V_BP)
  };

  timing_t        act_q;
  timing_t        shd_q;
  timing_t        cfg;
  logic           shd_full;
  logic [W-1:0]   hc;
  logic [W-1:0]   vc;
  logic [W+1:0]   hc_x;
  logic [W+1:0]   vc_x;
  logic [W+1:0]   h_tot;
  logic [W+1:0]   v_tot;
  logic [W+1:0]   hs_beg;
  logic [W+1:0]   hs_end;
  logic [W+1:0]   vs_beg;
  logic [W+1:0]   vs_end;
  logic           last_h;
  logic           last_v;
  logic           wrap;
  logic           de_n;
  logic           hs_n;
  logic           vs_n;
  logic           ls_n;

  assign cfg = '{
    h_act: cfg_h_act, h_fp: cfg_h_fp,
    h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_act: cfg_v_act, v_fp: cfg_v_fp,
    v_sync: cfg_v_sync, v_bp: cfg_v_bp
  };

  assign cfg_ready = !shd_full;

  assign hc_x   = {2'b00, hc};
  assign vc_x   = {2'b00, vc};
  assign h_tot  = h_total(act_q);
  assign v_tot  = v_total(act_q);
  assign hs_beg = {2'b00, act_q.h_act}
                + {2'b00, act_q.h_fp};
  assign hs_end = hs_beg + {2'b00, act_q.h_sync};
  assign vs_beg = {2'b00, act_q.v_act}
                + {2'b00, act_q.v_fp};
  assign vs_end = vs_beg + {2'b00, act_q.v_sync};

  assign last_h = (hc_x == h_tot - 1'b1);
  assign last_v = (vc_x == v_tot - 1'b1);
  assign wrap   = pix_en && last_h && last_v;

  assign de_n = (hc_x < {2'b00, act_q.h_act})
             && (vc_x < {2'b00, act_q.v_act});
  assign hs_n = (hc_x >= hs_beg) && (hc_x < hs_end);
  assign vs_n = (vc_x >= vs_beg) && (vc_x < vs_end);
  assign ls_n = (hc == '0);

  // Shadow: validate requests, hand over at frame wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      act_q    <= DEF_T;
      shd_q    <= '0;
      shd_full <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_valid && !shd_full) begin
        if (timing_valid(cfg)) begin
          shd_q    <= cfg;
          shd_full <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (wrap && shd_full) begin
        act_q    <= shd_q;
        shd_full <= 1'b0;
      end
    end
  end

  // Raster position, advanced one pixel per pix_en
  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (last_h) begin
        hc <= '0;
        vc <= last_v ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Outputs decoded from the position, one pix_en late
  always_ff @(posedge clock) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      de          <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_count     <= hc;
      v_count     <= vc;
      de          <= de_n;
      hsync       <= hs_n ? HS_POL : !HS_POL;
      vsync       <= vs_n ? VS_POL : !VS_POL;
      line_start  <= ls_n;
      frame_start <= ls_n && (vc == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a
// pixel-index raster model with a shadow handshake.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int W = TW;

  localparam timing_t DEF_T = '{
    h_act: 12'd6, h_fp: 12'd1, h_sync: 12'd2,
    h_bp: 12'd1, v_act: 12'd3, v_fp: 12'd1,
    v_sync: 12'd1, v_bp: 12'd1
  };
  localparam timing_t TINY = '{
    h_act: 12'd4, h_fp: 12'd1, h_sync: 12'd1,
    h_bp: 12'd1, v_act: 12'd2, v_fp: 12'd1,
    v_sync: 12'd1, v_bp: 12'd1
  };
  localparam timing_t SMALL = '{
    h_act: 12'd3, h_fp: 12'd0, h_sync: 12'd1,
    h_bp: 12'd0, v_act: 12'd1, v_fp: 12'd0,
    v_sync: 12'd1, v_bp: 12'd0
  };

  logic         clock = 1'b0;
  logic         reset;
  logic         pix_en;
  logic         cfg_valid;
  logic         no_cfg = 1'b0;
  timing_t      drv;
  logic         cfg_ready, cfg_err;
  logic [W-1:0] h_count, v_count;
  logic         de, hsync, vsync;
  logic         line_start, frame_start;
  logic         d_rdy, d_err;
  logic [W-1:0] d_h, d_v;
  logic         d_de, d_hs, d_vs, d_ls, d_fs;

  always #5 clock = ~clock;

  video_timing_gen #(
    .W(W),
    .DEF_H_ACT(6), .DEF_H_FP(1),
    .DEF_H_SYNC(2), .DEF_H_BP(1),
    .DEF_V_ACT(3), .DEF_V_FP(1),
    .DEF_V_SYNC(1), .DEF_V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .clock(clock), .reset(reset),
    .pix_en(pix_en),
    .cfg_h_act(drv.h_act), .cfg_h_fp(drv.h_fp),
    .cfg_h_sync(drv.h_sync), .cfg_h_bp(drv.h_bp),
    .cfg_v_act(drv.v_act), .cfg_v_fp(drv.v_fp),
    .cfg_v_sync(drv.v_sync), .cfg_v_bp(drv.v_bp),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .h_count(h_count), .v_count(v_count),
    .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  video_timing_gen u_def (
    .clock(clock), .reset(reset),
    .pix_en(pix_en),
    .cfg_h_act(drv.h_act), .cfg_h_fp(drv.h_fp),
    .cfg_h_sync(drv.h_sync), .cfg_h_bp(drv.h_bp),
    .cfg_v_act(drv.v_act), .cfg_v_fp(drv.v_fp),
    .cfg_v_sync(drv.v_sync), .cfg_v_bp(drv.v_bp),
    .cfg_valid(no_cfg),
    .cfg_ready(d_rdy), .cfg_err(d_err),
    .h_count(d_h), .v_count(d_v),
    .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state: pixel index in frame + timings
  int           p, pd;
  timing_t      m_act, m_sh;
  bit           m_full;
  bit           def_chk = 0;
  logic [W-1:0] e_h, e_v, ed_h, ed_v;
  logic [4:0]   e_fl, ed_fl;
  logic         e_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int tot_h(input timing_t t);
    return int'(t.h_act) + int'(t.h_fp)
         + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int tot_v(input timing_t t);
    return int'(t.v_act) + int'(t.v_fp)
         + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  function automatic bit ok(input timing_t t);
    return t.h_act != 0 && t.h_sync != 0
        && t.v_act != 0 && t.v_sync != 0
        && tot_h(t) <= 4096 && tot_v(t) <= 4096;
  endfunction

  // flags = {de, hsync, vsync, line_start, frame_start}
  task automatic decode(input int pos,
                        input timing_t t,
                        output logic [W-1:0] h,
                        output logic [W-1:0] v,
                        output logic [4:0] fl);
    int ht, hh, vv, hb, vb;
    ht = tot_h(t);
    hh = pos % ht;
    vv = pos / ht;
    hb = int'(t.h_act) + int'(t.h_fp);
    vb = int'(t.v_act) + int'(t.v_fp);
    fl[4] = hh < int'(t.h_act) && vv < int'(t.v_act);
    fl[3] = hh >= hb && hh < hb + int'(t.h_sync);
    fl[2] = vv >= vb && vv < vb + int'(t.v_sync);
    fl[1] = hh == 0;
    fl[0] = pos == 0;
    h = W'(hh);
    v = W'(vv);
  endtask

  task automatic step();
    bit full0;
    @(posedge clock);
    if (reset) begin
      p = 0; pd = 0;
      m_act = DEF_T; m_full = 0;
      e_h = '0; e_v = '0; e_fl = '0; e_err = 0;
      ed_h = '0; ed_v = '0; ed_fl = '0;
    end else begin
      full0 = m_full;
      e_err = 0;
      if (cfg_valid && !full0) begin
        if (ok(drv)) begin
          m_sh = drv;
          m_full = 1;
        end else begin
          e_err = 1;
        end
      end
      if (pix_en) begin
        decode(p, m_act, e_h, e_v, e_fl);
        p++;
        if (p == tot_h(m_act) * tot_v(m_act)) begin
          p = 0;
          if (full0) begin
            m_act = m_sh;
            m_full = 0;
          end
        end
        decode(pd, TIMING_720P, ed_h, ed_v, ed_fl);
        pd = (pd + 1) % (1650 * 750);
      end
    end
    #1;
    chk("h_count", 32'(h_count), 32'(e_h));
    chk("v_count", 32'(v_count), 32'(e_v));
    chk("flags",
        {27'd0, de, hsync, vsync, line_start,
         frame_start}, {27'd0, e_fl});
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_full));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
    if (def_chk) begin
      chk("720p_h", 32'(d_h), 32'(ed_h));
      chk("720p_v", 32'(d_v), 32'(ed_v));
      chk("720p_de_hs", {30'd0, d_de, d_hs},
          {30'd0, ed_fl[4:3]});
    end
  endtask

  task automatic send(input timing_t t);
    drv = t;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic fs_period(input int want);
    int n;
    n = 0;
    while (!frame_start && n < 200) begin
      step(); n++;
    end
    n = 0;
    do begin
      step(); n++;
    end while (!frame_start && n < 200);
    chk("fs_period", 32'(n), 32'(want));
  endtask

  timing_t bad;

  initial begin
    reset = 1'b1; pix_en = 1'b0;
    cfg_valid = 1'b0; drv = DEF_T;
    step(); step();
    reset = 1'b0;
    step();
    // first pixel, then freeze/advance pattern
    pix_en = 1'b1; step();
    pix_en = 1'b0; step(); step();
    pix_en = 1'b1; step();
    pix_en = 1'b0; step();
    pix_en = 1'b1;
    repeat (7) step();
    // mid-frame config, applied at next wrap
    send(TINY);
    for (int i = 0; i < 200 && !cfg_ready; i++)
      step();
    chk("apply_wait", 32'(cfg_ready), 32'd1);
    fs_period(35);
    fs_period(35);
    // rejects: zero sync, H total 4097
    bad = TINY; bad.h_sync = 12'd0;
    send(bad); step(); step();
    bad = TINY;
    bad.h_act = 12'd4000; bad.h_fp = 12'd32;
    bad.h_sync = 12'd32; bad.h_bp = 12'd33;
    send(bad); step(); step();
    fs_period(35);
    // handshake exactly on the wrap cycle
    for (int i = 0; i < 100; i++) begin
      if (p == tot_h(m_act) * tot_v(m_act) - 1)
        break;
      step();
    end
    send(SMALL);
    fs_period(35);
    fs_period(8);
    fs_period(8);
    // H total 4096 accepted, then reset drops it
    bad.h_bp = 12'd32;
    send(bad);
    repeat (3) step();
    reset = 1'b1; step();
    reset = 1'b0;
    def_chk = 1;
    repeat (3400) step();
    def_chk = 0;
    fs_period(60);
    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      pix_en = ($urandom_range(3) != 0);
      reset = ($urandom_range(999) == 0);
      cfg_valid = ($urandom_range(15) == 0);
      drv.h_act  = W'($urandom_range(5));
      drv.h_fp   = W'($urandom_range(2));
      drv.h_sync = W'($urandom_range(2));
      drv.h_bp   = W'($urandom_range(2));
      drv.v_act  = W'($urandom_range(4));
      drv.v_fp   = W'($urandom_range(2));
      drv.v_sync = W'($urandom_range(2));
      drv.v_bp   = W'($urandom_range(2));
      step();
    end
    reset = 1'b0; cfg_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised, runtime-reconfigurable raster timing generator that replaces the fixed-mode pixel counter in the display path. It produces registered h/v counts, data-enable, hsync/vsync and frame/line start strobes from a pixel-rate enable. A new timing mode is accepted at any time through a one-entry shadow register and is applied only at a frame boundary, so the raster never tears. It sits between the pixel PLL/reset logic and the framebuffer read side and HDMI/VGA encoder.

## Interface
- W, 12, counter and timing-field width; maximum line or frame total is 2^W
- DEF_H_ACT / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 1280/110/40/220, horizontal timing after reset (720p)
- DEF_V_ACT / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 720/5/5/20, vertical timing after reset
- HS_POL / VS_POL, 1/1, sync active level (1 = active high)

Ports:
- clock  in  1  pixel-domain clock
- reset  in  1  synchronous reset, active high
- pix_en  in  1  advance one pixel this cycle
- cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  W each  requested horizontal timing
- cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  W each  requested vertical timing
- cfg_valid  in  1  config request
- cfg_ready  out  1  shadow register empty
- cfg_err  out  1  one-cycle pulse: handshaked config rejected
- h_count  out  W  pixel index within line
- v_count  out  W  line index within frame
- de  out  1  active-video pixel
- hsync / vsync  out  1  sync, polarity per HS_POL/VS_POL
- line_start  out  1  first pixel of every line
- frame_start  out  1  pixel (0,0)

## Operation
- Line layout: active, front porch, sync, back porch. Same order for frame lines. H_TOT = act+fp+sync+bp.
- Internal counters hc and vc change only on pix_en. hc wraps at H_TOT-1 to 0. vc increments on an hc wrap and wraps at V_TOT-1. The last count is exactly TOT-1, with no off-by-one.
- Outputs are registered from the internal counters on pix_en and lag them by one pix_en. All outputs are mutually aligned and hold their values while pix_en=0.
- de=1 iff hc<h_act and vc<v_act.
- hsync is active iff h_act+h_fp ≤ hc < h_act+h_fp+h_sync.
- vsync is active for whole lines in the vertical sync region.
- line_start=1 iff hc==0. frame_start=1 iff hc==0 and vc==0. Both are high for exactly one pix_en cycle.
- Config handshake: a transfer occurs when cfg_valid and cfg_ready are both high. The fields are validated in that same cycle.
  - Reject and pulse cfg_err, with the shadow left unchanged, if any of these hold: h_act, h_sync, v_act or v_sync is 0; H_TOT > 2^W; V_TOT > 2^W. Totals are computed at W+2 bits.
  - Otherwise the fields are loaded into the shadow and cfg_ready drops.
- Apply: on the pix_en cycle where the internal counter wraps from (H_TOT-1, V_TOT-1) to (0,0), a full shadow becomes the active timing and cfg_ready rises the next cycle. Porches may be 0.
- Simultaneous events: a config accepted in the same cycle as the wrap is not applied at that wrap; it is applied at the following frame boundary. With cfg_ready=0, cfg_valid is ignored and cfg_err is not raised.

## Timing
- Reset values:
  - Internal and output counts are 0.
  - de, line_start, frame_start and cfg_err are 0.
  - hsync = !HS_POL, vsync = !VS_POL.
  - cfg_ready = 1.
  - Active timing = DEF_*; shadow is empty.
- First pix_en after reset deasserts: outputs show (0,0) with de=1, line_start=1 and frame_start=1.
- Latency from cfg handshake to use is at most one full frame. The new timing is visible on outputs one pix_en after the wrap, where frame_start=1 with count (0,0).
- Reset asserted mid-frame or mid-handshake returns all state to reset values in the next cycle. A pending shadow is discarded.
- cfg_err is asserted the cycle after the handshake and is high for one clock cycle regardless of pix_en.

## Structure
- Package video_timing_pkg:
  - timing_t struct with h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp, each W bits.
  - Constants TIMING_720P (1280/110/40/220, 720/5/5/20) and TIMING_1080P (1920/88/44/148, 1080/4/5/36).
  - Function timing_valid(timing_t).
- No sub-module. Reset is already synchronous at this level, so no reset synchroniser is instantiated here. Counter, shadow and decode logic live in a single module.

## Test plan
- Tiny mode H=4/1/1/1 (total 7), V=2/1/1/1 (total 5), pix_en=1: h_count runs 0..6, de high on counts 0..3 of lines 0..1, hsync active at h_count 5, vsync active on line 3, frame_start every 35 cycles.
- pix_en toggling 1-0-1: outputs freeze during the 0 cycles, and frame_start spans exactly one pix_en cycle.
- Config H=4/1/1/1 accepted mid-frame: cfg_ready=0 until the wrap, the old timing runs to (H_TOT-1, V_TOT-1), and the new period starts at frame_start.
- Config with h_sync=0, or H_TOT=4097 at W=12: cfg_err pulses once, cfg_ready stays 1, and the timing is unchanged.
- Config handshaked on the wrap cycle: not applied at that wrap; applied one full frame later.
- Reset mid-line with a pending shadow: next cycle all outputs are at reset values and cfg_ready=1; the DEF_* 720p timing resumes (total 1650×750).
